el_scan_ctrl: RTL and testbench

Read-side scan controller for the dual-scan EL panel. It sequences reads from the two 1-bit GRAMs (GRAM1 holds the upper half, GRAM2 the lower half) at a shared address. It packs 4 pixels per nibble and drives the panel's UD/LD nibble buses with VCLK, HS and VS. It sits opposite the video-side GRAM writer and owns the GRAM read ports.

---
 rtl/el_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_el_scan_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/el_scan_ctrl.sv
// el_scan_ctrl: read-side scan controller for a dual-scan EL panel.
// Reads two 1-bit GRAMs (upper/lower half) at a shared address, packs
// 4 pixels per nibble and drives the panel with ud/ld, vclk, hs and vs.
// Optional build macro EL_INVERT_EN: drive ud/ld inverted for
// negative-polarity panels (reset and idle value stays 0).
// Ports:
//   pclk, rst (async, active-low), en (sampled at frame boundaries)
//   ram_rd_en, ram_addr        : shared GRAM read port
//   ram1_q, ram2_q             : GRAM1 (upper) / GRAM2 (lower) read data
//   ud, ld                     : upper/lower panel nibbles
//   vclk, hs, vs               : panel nibble clock, line latch, frame marker
//   frame_done                 : 1-cycle pulse at end of the last line
//   scan_row                   : row currently being scanned
module el_scan_ctrl #(
    parameter int X_RES    = 640,
    parameter int ROWS     = 200,
    parameter int RD_LAT   = 1,
    parameter int VCLK_DIV = 8,
    parameter int HS_CYC   = 4,
    parameter int FGAP_CYC = 64
) (
    input  logic                            pclk,
    input  logic                            rst,
    input  logic                            en,
    output logic                            ram_rd_en,
    output logic [$clog2(X_RES*ROWS)-1:0]   ram_addr,
    input  logic                            ram1_q,
    input  logic                            ram2_q,
    output logic [3:0]                      ud,
    output logic [3:0]                      ld,
    output logic                            vclk,
    output logic                            hs,
    output logic                            vs,
    output logic                            frame_done,
    output logic [$clog2(ROWS)-1:0]         scan_row
);
    localparam int AW    = $clog2(X_RES*ROWS);
    localparam int PW    = $clog2(VCLK_DIV);
    localparam int SW    = $clog2(X_RES/4);
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2((HS_CYC > FGAP_CYC ? HS_CYC : FGAP_CYC) + 1);
    localparam int P_OUT = 4 + RD_LAT;
`ifdef EL_INVERT_EN
    localparam logic [3:0] POL = 4'hF;
`else
    localparam logic [3:0] POL = 4'h0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, HSYNC, FGAP} state_t;
    state_t state, state_nx;

    logic [PW-1:0] phase;
    logic [SW-1:0] slot;
    logic [RW-1:0] row;
    logic [CW-1:0] cnt;
    logic [3:0]    nib1, nib2;
    logic          phase_end, slot_end, hs_end, gap_end, last_row, rd_phase;

    assign phase_end = phase == PW'(VCLK_DIV-1);
    assign slot_end  = slot == SW'(X_RES/4-1);
    assign hs_end    = cnt == CW'(HS_CYC-1);
    assign gap_end   = cnt == CW'(FGAP_CYC-1);
    assign last_row  = row == RW'(ROWS-1);
    // Returned data lags the address by RD_LAT, so capture phases trail issue phases.
    assign rd_phase  = phase >= PW'(RD_LAT) && phase < PW'(RD_LAT+4);
    assign scan_row  = row;
    assign ram_addr  = ram_rd_en ? AW'(row) * AW'(X_RES) + AW'({slot, phase[1:0]}) : '0;

    always_ff @(posedge pclk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    always_comb begin
        state_nx   = state;
        ram_rd_en  = 1'b0;
        vclk       = 1'b0;
        hs         = 1'b0;
        vs         = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:  state_nx = en ? SHIFT : IDLE;
            SHIFT: begin
                ram_rd_en = phase < PW'(4);
                // High after the nibble update; falls at the phase wrap so the panel sees stable data.
                vclk      = phase > PW'(P_OUT);
                state_nx  = phase_end && slot_end ? HSYNC : SHIFT;
            end
            HSYNC: begin
                hs         = 1'b1;
                vs         = row == '0;
                frame_done = hs_end && last_row;
                state_nx   = !hs_end ? HSYNC : last_row ? FGAP : SHIFT;
            end
            FGAP:  state_nx = !gap_end ? FGAP : en ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
            slot  <= '0;
            row   <= '0;
            cnt   <= '0;
            nib1  <= '0;
            nib2  <= '0;
            ud    <= '0;
            ld    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    phase <= '0;
                    slot  <= '0;
                    row   <= '0;
                    cnt   <= '0;
                    ud    <= '0;
                    ld    <= '0;
                end
                SHIFT: begin
                    cnt   <= '0;
                    phase <= phase_end ? '0 : phase + 1'b1;
                    if (phase_end) slot <= slot_end ? '0 : slot + 1'b1;
                    // First pixel of the slot ends up in bit 3.
                    if (rd_phase) begin
                        nib1 <= {nib1[2:0], ram1_q};
                        nib2 <= {nib2[2:0], ram2_q};
                    end
                    if (phase == PW'(P_OUT)) begin
                        ud <= nib1 ^ POL;
                        ld <= nib2 ^ POL;
                    end
                end
                HSYNC: begin
                    cnt <= hs_end ? '0 : cnt + 1'b1;
                    if (hs_end && !last_row) row <= row + 1'b1;
                end
                FGAP: begin
                    cnt <= gap_end ? '0 : cnt + 1'b1;
                    if (gap_end) row <= '0;
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_el_scan_ctrl.sv
module tb_el_scan_ctrl;
    localparam int X = 16, R = 4, VD = 8, HC = 4, FG = 10, RL = 1;
    localparam int FP = R * ((X/4)*VD + HC) + FG;
`ifdef EL_INVERT_EN
    localparam logic [3:0] POL = 4'hF;
`else
    localparam logic [3:0] POL = 4'h0;
`endif

    logic       clk = 1'b0, rst_n = 1'b1, en = 1'b0, q1 = 1'b0, q2 = 1'b0;
    logic       rd_en, vclk, hs, vs, fd;
    logic [5:0] addr;
    logic [3:0] ud, ld;
    logic [1:0] srow;
    logic       mem1 [64];
    logic       mem2 [64];
    int         vec = 0, err = 0;

    int         hs_n, vs_n, vs_bad, vs_first, fd_n, fd_at, falls, rd_n, a32_at;
    logic [3:0] fud [16];
    logic [3:0] fld [16];
    logic [5:0] alog [64];

    el_scan_ctrl #(.X_RES(X), .ROWS(R), .RD_LAT(RL), .VCLK_DIV(VD), .HS_CYC(HC), .FGAP_CYC(FG)) dut (
        .pclk(clk), .rst(rst_n), .en(en), .ram_rd_en(rd_en), .ram_addr(addr),
        .ram1_q(q1), .ram2_q(q2), .ud(ud), .ld(ld), .vclk(vclk), .hs(hs), .vs(vs),
        .frame_done(fd), .scan_row(srow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) begin
        q1 <= mem1[addr];
        q2 <= mem2[addr];
    end

    task automatic wait_fd;
        int n = 0;
        @(negedge clk);
        while (fd !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        vec++;
        if (fd !== 1'b1) begin err++; $display("FAIL wait_frame_done got=%b exp=1", fd); end
    endtask

    task automatic capture_frame;
        logic pv;
        wait_fd();
        hs_n = 0; vs_n = 0; vs_bad = 0; vs_first = -1; fd_n = 0; fd_at = -1;
        falls = 0; rd_n = 0; a32_at = -1;
        pv = vclk;
        for (int i = 1; i <= FP; i++) begin
            @(negedge clk);
            if (hs) hs_n++;
            if (vs) begin vs_n++; if (vs_first < 0) vs_first = i; end
            if (vs && !hs) vs_bad++;
            if (fd) begin fd_n++; fd_at = i; end
            if (pv && !vclk) begin
                if (falls < 16) begin fud[falls] = ud; fld[falls] = ld; end
                falls++;
            end
            if (rd_en) begin
                if (rd_n < 64) alog[rd_n] = addr;
                if (rd_n == 32) a32_at = i;
                rd_n++;
            end
            pv = vclk;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if ({ud, ld, vclk, hs, vs, rd_en, fd, addr, srow} !== '0) begin
            err++; $display("FAIL reset_outputs got=%h exp=0", {ud, ld, vclk, hs, vs, rd_en, fd, addr, srow});
        end
        repeat (3) @(negedge clk);
        vec++;
        if ({ud, ld, vclk, hs, vs, rd_en, fd} !== '0) begin
            err++; $display("FAIL reset_held got=%h exp=0", {ud, ld, vclk, hs, vs, rd_en, fd});
        end
        en = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic test_frame;
        capture_frame();
        vec++; if (fd_at !== FP) begin err++; $display("FAIL frame_period got=%0d exp=%0d", fd_at, FP); end
        vec++; if (fd_n !== 1) begin err++; $display("FAIL frame_done_count got=%0d exp=1", fd_n); end
        vec++; if (hs_n !== R*HC) begin err++; $display("FAIL hs_cycles got=%0d exp=%0d", hs_n, R*HC); end
        vec++; if (vs_n !== HC) begin err++; $display("FAIL vs_cycles got=%0d exp=%0d", vs_n, HC); end
        vec++; if (vs_bad !== 0) begin err++; $display("FAIL vs_outside_hs got=%0d exp=0", vs_bad); end
        vec++; if (vs_first !== 43) begin err++; $display("FAIL vs_position got=%0d exp=43", vs_first); end
        vec++; if (falls !== R*X/4) begin err++; $display("FAIL vclk_falls got=%0d exp=%0d", falls, R*X/4); end
    endtask

    task automatic test_data;
        logic [3:0] eu [4];
        eu[0] = 4'h8; eu[1] = 4'h0; eu[2] = 4'h0; eu[3] = 4'h1;
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (fud[4+k] !== (eu[k] ^ POL)) begin
                err++; $display("FAIL ud_row1_slot%0d got=%h exp=%h", k, fud[4+k], eu[k] ^ POL);
            end
            vec++;
            if (fld[4+k] !== (4'hF ^ POL)) begin
                err++; $display("FAIL ld_row1_slot%0d got=%h exp=%h", k, fld[4+k], 4'hF ^ POL);
            end
        end
        vec++;
        if (fud[0] !== POL) begin err++; $display("FAIL ud_row0_slot0 got=%h exp=%h", fud[0], POL); end
    endtask

    task automatic test_addr;
        capture_frame();
        vec++; if (rd_n !== X*R) begin err++; $display("FAIL rd_en_cycles got=%0d exp=%0d", rd_n, X*R); end
        for (int j = 0; j < 64; j++) begin
            vec++;
            if (alog[j] !== 6'(j)) begin err++; $display("FAIL addr_seq_%0d got=%0d exp=%0d", j, alog[j], j); end
        end
        vec++; if (a32_at !== 83) begin err++; $display("FAIL row2_start got=%0d exp=83", a32_at); end
    endtask

    task automatic test_en_drop;
        int n = 0, busy = 0;
        while (srow !== 2'd1 && n < 400) begin @(negedge clk); n++; end
        vec++; if (srow !== 2'd1) begin err++; $display("FAIL reach_row1 got=%0d exp=1", srow); end
        en = 1'b0;
        wait_fd();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (hs || rd_en || vclk || vs) busy++;
            if (i == 15) begin
                vec++;
                if ({ud, ld, vclk, hs, vs, rd_en, fd, addr, srow} !== '0) begin
                    err++; $display("FAIL idle_outputs got=%h exp=0", {ud, ld, vclk, hs, vs, rd_en, fd, addr, srow});
                end
            end
        end
        vec++; if (busy !== 0) begin err++; $display("FAIL idle_activity got=%0d exp=0", busy); end
        en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (hs !== 1'b1 && n < 200);
        vec++; if (n !== 33) begin err++; $display("FAIL restart_hs_delay got=%0d exp=33", n); end
        vec++; if (vs !== 1'b1) begin err++; $display("FAIL restart_vs got=%b exp=1", vs); end
        vec++; if (srow !== 2'd0) begin err++; $display("FAIL restart_row got=%0d exp=0", srow); end
    endtask

    task automatic test_reset_mid;
        wait_fd();
        repeat (33) @(negedge clk);
        vec++; if (vclk !== 1'b1) begin err++; $display("FAIL pre_reset_vclk got=%b exp=1", vclk); end
        vec++; if (ld !== (4'hF ^ POL)) begin err++; $display("FAIL pre_reset_ld got=%h exp=%h", ld, 4'hF ^ POL); end
        #1 rst_n = 1'b0;
        #1;
        vec++;
        if ({ud, ld, vclk, hs, vs, rd_en, fd, addr, srow} !== '0) begin
            err++; $display("FAIL async_clear got=%h exp=0", {ud, ld, vclk, hs, vs, rd_en, fd, addr, srow});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vec++; if (rd_en !== 1'b1 || addr !== 6'd0) begin err++; $display("FAIL restart_addr0 got=%b/%0d exp=1/0", rd_en, addr); end
        vec++; if (srow !== 2'd0) begin err++; $display("FAIL restart_scan_row got=%0d exp=0", srow); end
        @(negedge clk);
        vec++; if (addr !== 6'd1) begin err++; $display("FAIL restart_addr1 got=%0d exp=1", addr); end
    endtask

    initial begin
        for (int a = 0; a < 64; a++) begin
            mem1[a] = 1'b0;
            mem2[a] = 1'b1;
        end
        mem1[16] = 1'b1;
        mem1[31] = 1'b1;
        test_reset();
        test_frame();
        test_data();
        test_addr();
        test_en_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
